fb_rect_fill: RTL and testbench

Frame-buffer writer. It owns the write port (port A) of the dual-port frame-buffer bRAM, while the VGA scan-out reads through port B. It accepts rectangle-fill commands over a valid/ready handshake, clips each rectangle to the screen, and writes one 12-bit RGB pixel per clock in raster order. Full-screen clear is a rectangle command covering the whole screen.

---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_clip.sv | 31 +++
 rtl/fb_rect_fill.sv | 150 +++++++++++++++
 tb/tb_fb_rect_fill.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Frame-buffer geometry, pixel type and writer FSM encoding shared by the
// rectangle writer and the VGA scan-out, which use the same stride and address map.
package fb_pkg;
    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ADDR_W  = 19;
    localparam int COORD_W = 10;
    localparam int PIX_W   = 12;

    // {R[3:0], G[3:0], B[3:0]}
    typedef logic [PIX_W-1:0] rgb444_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLIP,
        ST_FILL,
        ST_DONE
    } fill_state_e;
endpackage

// File: rtl/fb_clip.sv
// Clips a fill rectangle to the screen. It produces exclusive right/bottom edges
// and flags rectangles that would produce no pixels.
module fb_clip #(
    parameter int H_RES   = fb_pkg::H_RES,
    parameter int V_RES   = fb_pkg::V_RES,
    parameter int COORD_W = fb_pkg::COORD_W
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] w_i,
    input  logic [COORD_W-1:0] h_i,
    output logic [COORD_W:0]   x_end_o,
    output logic [COORD_W:0]   y_end_o,
    output logic               degen_o
);
    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

    logic [COORD_W:0] x_sum;
    logic [COORD_W:0] y_sum;

    // One extra bit on the sums so a far-right/bottom rectangle cannot wrap.
    always_comb begin
        x_sum   = {1'b0, x_i} + {1'b0, w_i};
        y_sum   = {1'b0, y_i} + {1'b0, h_i};
        x_end_o = (x_sum > H_LIM) ? H_LIM : x_sum;
        y_end_o = (y_sum > V_LIM) ? V_LIM : y_sum;
        degen_o = (w_i == '0) || (h_i == '0) ||
                  ({1'b0, x_i} >= H_LIM) || ({1'b0, y_i} >= V_LIM);
    end
endmodule

// File: rtl/fb_rect_fill.sv
// Frame-buffer port-A writer: accepts rectangle-fill commands, clips them to the
// screen and writes one pixel per clock in raster order.
module fb_rect_fill #(
    parameter int H_RES   = fb_pkg::H_RES,
    parameter int V_RES   = fb_pkg::V_RES,
    parameter int ADDR_W  = fb_pkg::ADDR_W,
    parameter int COORD_W = fb_pkg::COORD_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [COORD_W-1:0]  cmd_x,
    input  logic [COORD_W-1:0]  cmd_y,
    input  logic [COORD_W-1:0]  cmd_w,
    input  logic [COORD_W-1:0]  cmd_h,
    input  fb_pkg::rgb444_t     cmd_color,
    output logic                mem_wea,
    output logic [ADDR_W-1:0]   mem_addr,
    output fb_pkg::rgb444_t     mem_din,
    output logic                busy,
    output logic                done
);
    import fb_pkg::*;

    localparam logic [ADDR_W-1:0]  STRIDE = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0]  A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [COORD_W-1:0] C_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic [COORD_W:0]   E_ONE  = {{COORD_W{1'b0}}, 1'b1};

    fill_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
    rgb444_t            color_q;
    logic [COORD_W:0]   x_end_q, y_end_q, x_end_c, y_end_c;
    logic               degen_c;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d, addr_d;
    rgb444_t            din_d;
    logic               ready_d, busy_d, done_d, wea_d;
    logic               accept, col_last, row_last;

    assign accept   = cmd_valid && cmd_ready;
    assign col_last = (({1'b0, cx_q} + E_ONE) == x_end_q);
    assign row_last = (({1'b0, cy_q} + E_ONE) == y_end_q);

    fb_clip #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COORD_W (COORD_W)
    ) u_clip (
        .x_i     (x_q),
        .y_i     (y_q),
        .w_i     (w_q),
        .h_i     (h_q),
        .x_end_o (x_end_c),
        .y_end_o (y_end_c),
        .degen_o (degen_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CLIP;
            ST_CLIP: state_d = degen_c ? ST_DONE : ST_FILL;
            ST_FILL: if (col_last && row_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        wea_d   = (state_d == ST_FILL);
    end

    // The address is held on the last pixel and on degenerate commands so it never leaves the frame.
    always_comb begin
        cx_d       = cx_q;
        cy_d       = cy_q;
        row_base_d = row_base_q;
        addr_d     = mem_addr;
        din_d      = mem_din;
        case (state_q)
            ST_CLIP: begin
                din_d = color_q;
                if (!degen_c) begin
                    cx_d       = x_q;
                    cy_d       = y_q;
                    row_base_d = ADDR_W'(y_q) * STRIDE;
                    addr_d     = row_base_d + ADDR_W'(x_q);
                end
            end
            ST_FILL: begin
                if (!col_last) begin
                    cx_d   = cx_q + C_ONE;
                    addr_d = mem_addr + A_ONE;
                end else if (!row_last) begin
                    cx_d       = x_q;
                    cy_d       = cy_q + C_ONE;
                    row_base_d = row_base_q + STRIDE;
                    addr_d     = row_base_d + ADDR_W'(x_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
        end
        if (state_q == ST_CLIP) begin
            x_end_q <= x_end_c;
            y_end_q <= y_end_c;
        end
        cx_q       <= cx_d;
        cy_q       <= cy_d;
        row_base_q <= row_base_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_wea   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            cmd_ready <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
            mem_wea   <= wea_d;
            mem_addr  <= addr_d;
            mem_din   <= din_d;
        end
    end
endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: a full-size instance for addressing, clipping and
// reset behaviour, plus a 16x12 instance for the whole-screen clear.
module tb_fb_rect_fill;
    logic        clk = 1'b0;
    logic        rstn;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, mem_wea, busy, done;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [11:0] cmd_color, mem_din;
    logic [18:0] mem_addr;

    logic        s_valid, s_ready, s_wea, s_busy, s_done;
    logic [9:0]  s_x, s_y, s_w, s_h;
    logic [11:0] s_color, s_din;
    logic [7:0]  s_addr;

    fb_rect_fill u_dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done)
    );

    fb_rect_fill #(.H_RES(16), .V_RES(12), .ADDR_W(8), .COORD_W(10)) u_small (
        .clk(clk), .rstn(rstn), .cmd_valid(s_valid), .cmd_ready(s_ready),
        .cmd_x(s_x), .cmd_y(s_y), .cmd_w(s_w), .cmd_h(s_h), .cmd_color(s_color),
        .mem_wea(s_wea), .mem_addr(s_addr), .mem_din(s_din), .busy(s_busy), .done(s_done)
    );

    int          cyc = 0;
    int unsigned wa[$], s_wa[$], eq[$];
    int          wc[$], dq[$], s_wc[$], s_dq[$];
    logic [11:0] wd[$], s_wd[$];
    logic [11:0] sfb [192];
    int          passed = 0, total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wea) begin
            wa.push_back(32'(mem_addr)); wd.push_back(mem_din); wc.push_back(cyc);
        end
        if (done) dq.push_back(cyc);
        if (s_wea) begin
            s_wa.push_back(32'(s_addr)); s_wd.push_back(s_din); s_wc.push_back(cyc);
            if (s_addr < 8'd192) sfb[s_addr] <= s_din;
        end
        if (s_done) s_dq.push_back(cyc);
    end

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(int x, int y, int w, int h, int c, output int acc);
        wa.delete(); wd.delete(); wc.delete(); dq.delete();
        for (int n = 0; n < 20 && !cmd_ready; n++) tick();
        chk("ready_idle", int'(cmd_ready), 1);
        chk("busy_idle", int'(busy), 0);
        cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
        cmd_color = 12'(c); cmd_valid = 1'b1;
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '1; cmd_h = '1; cmd_color = 12'hFFF;
        chk("clip_ready", int'(cmd_ready), 0);
        chk("clip_busy", int'(busy), 1);
    endtask

    task automatic wait_done(int limit);
        for (int n = 0; n < limit && dq.size() == 0; n++) tick();
    endtask

    task automatic verify(string tag, int acc, int c);
        int ba = 0, bd = 0, bc = 0;
        chk({tag, "_nwr"}, wa.size(), eq.size());
        for (int i = 0; i < wa.size() && i < eq.size(); i++) begin
            if (wa[i] != eq[i]) ba++;
            if (int'(wd[i]) != c) bd++;
            if (wc[i] != acc + 1 + i) bc++;
        end
        chk({tag, "_addr_err"}, ba, 0);
        chk({tag, "_din_err"}, bd, 0);
        chk({tag, "_timing_err"}, bc, 0);
        chk({tag, "_ndone"}, dq.size(), 1);
        chk({tag, "_done_cyc"}, (dq.size() > 0) ? dq[0] : -1, acc + 1 + eq.size());
    endtask

    task automatic small_fill(int c, int w, int h);
        int acc, ba = 0, bc = 0, bd = 0, nz = 0;
        s_wa.delete(); s_wd.delete(); s_wc.delete(); s_dq.delete();
        for (int n = 0; n < 20 && !s_ready; n++) tick();
        chk("s_ready", int'(s_ready), 1);
        s_x = '0; s_y = '0; s_w = 10'(w); s_h = 10'(h); s_color = 12'(c); s_valid = 1'b1;
        tick();
        acc = cyc;
        s_valid = 1'b0; s_w = '0; s_color = 12'h555;
        for (int n = 0; n < 400 && s_dq.size() == 0; n++) tick();
        tick();
        chk("s_nwr", s_wa.size(), 192);
        for (int i = 0; i < s_wa.size(); i++) begin
            if (s_wa[i] != 32'(i)) ba++;
            if (s_wc[i] != acc + 1 + i) bc++;
            if (int'(s_wd[i]) != c) bd++;
        end
        for (int i = 0; i < 192; i++) if (int'(sfb[i]) != c) nz++;
        chk("s_addr_err", ba, 0);
        chk("s_timing_err", bc, 0);
        chk("s_din_err", bd, 0);
        chk("s_fb_err", nz, 0);
        chk("s_done_cyc", (s_dq.size() > 0) ? s_dq[0] : -1, acc + 193);
        chk("s_busy_after", int'(s_busy), 0);
    endtask

    initial begin
        int acc, prev_last;
        rstn = 1'b0; cmd_valid = 1'b0; s_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        s_x = '0; s_y = '0; s_w = '0; s_h = '0; s_color = '0;
        tick(); tick();
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wea", int'(mem_wea), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_din", int'(mem_din), 0);
        rstn = 1'b1;
        repeat (3) tick();
        chk("idle_ready", int'(cmd_ready), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_nwr", wa.size(), 0);
        chk("idle_ndone", dq.size(), 0);

        issue(1, 1, 2, 2, 12'hF00, acc);
        wait_done(50);
        eq = '{641, 642, 1281, 1282};
        verify("rect", acc, 12'hF00);
        prev_last = (wc.size() > 0) ? wc[wc.size()-1] : -100;

        issue(638, 478, 10, 10, 12'h0F0, acc);
        chk("b2b_accept", acc, prev_last + 3);
        wait_done(50);
        eq = '{306558, 306559, 307198, 307199};
        verify("clip", acc, 12'h0F0);
        chk("b2b_gap", (wc.size() > 0) ? wc[0] - prev_last : -1, 4);

        eq.delete();
        issue(5, 5, 0, 3, 12'h00F, acc);
        wait_done(20);
        verify("deg_w", acc, 12'h00F);
        issue(700, 5, 5, 5, 12'h00F, acc);
        wait_done(20);
        verify("deg_x", acc, 12'h00F);
        issue(0, 480, 5, 5, 12'h00F, acc);
        wait_done(20);
        verify("deg_y", acc, 12'h00F);
        chk("addr_bound", int'(mem_addr < 19'd307200), 1);

        small_fill(12'hABC, 20, 20);
        small_fill(12'h000, 16, 12);

        issue(10, 20, 100, 100, 12'h00F, acc);
        repeat (50) tick();
        rstn = 1'b0;
        #1;
        chk("abort_wea", int'(mem_wea), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_nwr", wa.size(), 50);
        chk("abort_first", (wa.size() > 0) ? int'(wa[0]) : -1, 12810);
        chk("abort_last", (wa.size() > 49) ? int'(wa[49]) : -1, 12859);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("abort_ndone", dq.size(), 0);
        chk("abort_nwr_after", wa.size(), 50);

        issue(1, 1, 2, 2, 12'h123, acc);
        wait_done(50);
        eq = '{641, 642, 1281, 1282};
        verify("post_rst", acc, 12'h123);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
